cdb_arbiter: RTL and testbench

Parametrised common-data-bus scheduler and result mux for the out-of-order core's issue stage. It replaces the fixed four-unit issue arbitration with NUM_CH execution channels, each with its own latency and pipelined/non-pipelined mode. It reserves future CDB slots at grant time so that no two results ever collide. It registers the winning result onto the CDB one cycle after the unit produces it.

---
 rtl/cdb_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_cdb_arbiter.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_arbiter
//  Purpose  : Common-data-bus scheduler and result mux. Reserves future CDB
//             capture slots at grant time so results never collide, and
//             registers the selected channel's result onto the CDB.
//  Options  : CDB_ARB_BRANCH_EN - forward branch flags; branch results
//             suppress the tag broadcast (cdb_valid = 0).
//  Revision : 1.0  initial release
// ============================================================================
module cdb_arbiter #(
  parameter int                  NUM_CH  = 4,
  parameter int                  DATA_W  = 32,
  parameter int                  TAG_W   = 6,
  parameter logic [4*NUM_CH-1:0] CH_LAT  = 16'h1631,
  parameter logic [NUM_CH-1:0]   CH_PIPE = 4'b1011
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          ch_req,
  output logic [NUM_CH-1:0]          ch_grant,
  input  logic [NUM_CH*DATA_W-1:0]   ch_data,
  input  logic [NUM_CH*TAG_W-1:0]    ch_tag,
  input  logic [NUM_CH-1:0]          ch_branch,
  input  logic [NUM_CH-1:0]          ch_branch_taken,
  output logic                       cdb_valid,
  output logic [DATA_W-1:0]          cdb_data,
  output logic [TAG_W-1:0]           cdb_tag,
  output logic                       cdb_branch,
  output logic                       cdb_branch_taken
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int SLOTS = 16;

  // Slot reservation map and per-slot owning channel
  logic [SLOTS-1:0]  slot_q, slot_d;
  logic [SLOTS-1:0]  w_slot_sh;
  logic [IDX_W-1:0]  own_q [SLOTS];
  logic [IDX_W-1:0]  own_d [SLOTS];

  // Round-robin pointer
  logic [IDX_W-1:0]  rr_q, rr_d;

  // Non-pipelined occupancy counters
  logic [3:0]        busy_cnt_q [NUM_CH];
  logic [3:0]        busy_cnt_d [NUM_CH];
  logic [3:0]        w_cnt_dec  [NUM_CH];
  logic [3:0]        w_lat      [NUM_CH];
  logic [NUM_CH-1:0] w_busy;
  logic [NUM_CH-1:0] w_elig;

  // Arbitration scan results
  logic [NUM_CH-1:0] w_grant;
  logic              w_denied;
  logic              w_found;
  logic [IDX_W-1:0]  w_first;
  logic [SLOTS-1:0]  w_lat_used;
  logic [IDX_W:0]    w_idx_sum;
  logic [IDX_W-1:0]  w_idx;

  // Capture-side mux
  logic              w_cap;
  logic [IDX_W-1:0]  w_sel;
  logic [DATA_W-1:0] w_sel_data;
  logic [TAG_W-1:0]  w_sel_tag;
  logic              w_sel_br;
  logic              w_sel_tk;

  // Reservation view after this cycle's shift; bit 0 is the slot captured now
  assign w_slot_sh = {1'b0, slot_q[SLOTS-1:1]};
  assign w_cap     = w_slot_sh[0];
  assign w_sel     = own_q[1];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign w_lat[i]     = CH_LAT[4*i +: 4];
    assign w_cnt_dec[i] = (busy_cnt_q[i] == 4'd0) ? 4'd0 : busy_cnt_q[i] - 4'd1;
    // Busy is judged on the decremented count so the channel frees up in
    // the same cycle its result is captured.
    assign w_busy[i]    = ~CH_PIPE[i] & (w_cnt_dec[i] != 4'd0);
    assign w_elig[i]    = ch_req[i] & ~w_slot_sh[w_lat[i]] & ~w_busy[i] & ~reset;
  end

  assign ch_grant = w_grant;

  // Rotating-priority scan; a later channel loses only to an earlier winner of equal latency
  always_comb begin
    w_grant    = '0;
    w_denied   = 1'b0;
    w_found    = 1'b0;
    w_first    = '0;
    w_lat_used = '0;
    w_idx_sum  = '0;
    w_idx      = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      w_idx_sum = {1'b0, rr_q} + (IDX_W+1)'(j);
      if (w_idx_sum >= (IDX_W+1)'(NUM_CH)) begin
        w_idx_sum = w_idx_sum - (IDX_W+1)'(NUM_CH);
      end
      w_idx = w_idx_sum[IDX_W-1:0];
      if (w_elig[w_idx]) begin
        if (w_lat_used[w_lat[w_idx]]) begin
          w_denied = 1'b1;
        end else begin
          w_grant[w_idx]             = 1'b1;
          w_lat_used[w_lat[w_idx]] = 1'b1;
          if (!w_found) begin
            w_found = 1'b1;
            w_first = w_idx;
          end
        end
      end
    end
  end

  // Next-state for reservations, owners, pointer and busy counters
  always_comb begin
    slot_d = w_slot_sh;
    for (int k = 0; k < SLOTS-1; k++) begin
      own_d[k] = own_q[k+1];
    end
    own_d[SLOTS-1] = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      busy_cnt_d[i] = w_cnt_dec[i];
      if (w_grant[i]) begin
        slot_d[w_lat[i]] = 1'b1;
        own_d[w_lat[i]]  = IDX_W'(i);
        busy_cnt_d[i]    = w_lat[i];
      end
    end
    rr_d = rr_q;
    if (w_denied) begin
      rr_d = (w_first == IDX_W'(NUM_CH-1)) ? '0 : w_first + 1'b1;
    end
  end

  // Result mux selecting the channel that owns the current capture slot
  always_comb begin
    w_sel_data = '0;
    w_sel_tag  = '0;
    w_sel_br   = 1'b0;
    w_sel_tk   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_sel == IDX_W'(i)) begin
        w_sel_data = ch_data[i*DATA_W +: DATA_W];
        w_sel_tag  = ch_tag[i*TAG_W +: TAG_W];
        w_sel_br   = ch_branch[i];
        w_sel_tk   = ch_branch_taken[i];
      end
    end
  end

  // Scheduler state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q <= '0;
      rr_q   <= '0;
      for (int k = 0; k < SLOTS; k++) begin
        own_q[k] <= '0;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        busy_cnt_q[i] <= '0;
      end
    end else begin
      slot_q <= slot_d;
      rr_q   <= rr_d;
      for (int k = 0; k < SLOTS; k++) begin
        own_q[k] <= own_d[k];
      end
      for (int i = 0; i < NUM_CH; i++) begin
        busy_cnt_q[i] <= busy_cnt_d[i];
      end
    end
  end

  // CDB output registers; idle cycles broadcast all-zero
  always_ff @(posedge clk) begin
    if (reset || !w_cap) begin
      cdb_valid        <= 1'b0;
      cdb_data         <= '0;
      cdb_tag          <= '0;
      cdb_branch       <= 1'b0;
      cdb_branch_taken <= 1'b0;
    end else begin
      cdb_data <= w_sel_data;
      cdb_tag  <= w_sel_tag;
`ifdef CDB_ARB_BRANCH_EN
      cdb_valid        <= ~w_sel_br;
      cdb_branch       <= w_sel_br;
      cdb_branch_taken <= w_sel_tk;
`else
      cdb_valid        <= 1'b1;
      cdb_branch       <= 1'b0;
      cdb_branch_taken <= 1'b0;
`endif
    end
  end

  // Slot 0 of the stored map and owner is never read (latency is at least 1)
`ifdef CDB_ARB_BRANCH_EN
  logic w_unused;
  assign w_unused = ^{slot_q[0], own_q[0]};
`else
  logic w_unused;
  assign w_unused = ^{slot_q[0], own_q[0], w_sel_br, w_sel_tk};
`endif

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cdb_arbiter
//  Purpose  : Self-checking bench for cdb_arbiter: directed scenarios plus
//             randomized traffic against an absolute-cycle reservation model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cdb_arbiter;

  localparam int              NUM_CH = 4;
  localparam int              DATA_W = 32;
  localparam int              TAG_W  = 6;
  localparam logic [15:0]     LAT_P  = 16'h1631;
  localparam logic [3:0]      PIPE_P = 4'b1011;

  logic                     clk;
  logic                     reset;
  logic [NUM_CH-1:0]        ch_req;
  logic [NUM_CH-1:0]        ch_grant;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH*TAG_W-1:0]  ch_tag;
  logic [NUM_CH-1:0]        ch_branch;
  logic [NUM_CH-1:0]        ch_branch_taken;
  logic                     cdb_valid;
  logic [DATA_W-1:0]        cdb_data;
  logic [TAG_W-1:0]         cdb_tag;
  logic                     cdb_branch;
  logic                     cdb_branch_taken;

  int  checks   = 0;
  int  failures = 0;
  bit  mon_en   = 0;
  bit  rand_br  = 0;

  cdb_arbiter #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W),
    .CH_LAT (LAT_P),
    .CH_PIPE(PIPE_P)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .ch_req          (ch_req),
    .ch_grant        (ch_grant),
    .ch_data         (ch_data),
    .ch_tag          (ch_tag),
    .ch_branch       (ch_branch),
    .ch_branch_taken (ch_branch_taken),
    .cdb_valid       (cdb_valid),
    .cdb_data        (cdb_data),
    .cdb_tag         (cdb_tag),
    .cdb_branch      (cdb_branch),
    .cdb_branch_taken(cdb_branch_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(int i);
    return int'(LAT_P[4*i +: 4]);
  endfunction

  // ---------------------------------------------------------------------
  // Reference model: reservations keyed by absolute capture cycle
  // ---------------------------------------------------------------------
  int               cyc = 0;
  int               owner [int];
  int               m_free [NUM_CH];
  int               m_rr = 0;
  logic [NUM_CH-1:0] m_grant;
  bit               m_el [NUM_CH];
  bit   [15:0]      m_used;
  bit               m_denied;
  int               m_first;
  int               m_ch;
  logic [15:0]      m_slot_sh;
  logic             e_valid = 0, e_br = 0, e_tk = 0;
  logic [TAG_W-1:0] e_tag  = '0;
  logic [DATA_W-1:0] e_data = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (cdb_valid !== e_valid || cdb_branch !== e_br || cdb_branch_taken !== e_tk ||
          cdb_tag !== e_tag || cdb_data !== e_data) begin
        failures++;
        $display("FAIL model_cdb cyc=%0d got v=%0b br=%0b tk=%0b tag=%0d data=%h want v=%0b br=%0b tk=%0b tag=%0d data=%h",
                 cyc, cdb_valid, cdb_branch, cdb_branch_taken, cdb_tag, cdb_data,
                 e_valid, e_br, e_tk, e_tag, e_data);
      end
      m_grant = '0;
      if (reset) begin
        e_valid = 0; e_br = 0; e_tk = 0; e_tag = '0; e_data = '0;
        owner.delete();
        for (int i = 0; i < NUM_CH; i++) m_free[i] = 0;
        m_rr = 0;
      end else begin
        if (owner.exists(cyc)) begin
          m_ch   = owner[cyc];
          e_data = ch_data[m_ch*DATA_W +: DATA_W];
          e_tag  = ch_tag[m_ch*TAG_W +: TAG_W];
`ifdef CDB_ARB_BRANCH_EN
          e_valid = !ch_branch[m_ch];
          e_br    = ch_branch[m_ch];
          e_tk    = ch_branch_taken[m_ch];
`else
          e_valid = 1; e_br = 0; e_tk = 0;
`endif
          owner.delete(cyc);
        end else begin
          e_valid = 0; e_br = 0; e_tk = 0; e_tag = '0; e_data = '0;
        end
        for (int i = 0; i < NUM_CH; i++) begin
          m_el[i] = ch_req[i] && !owner.exists(cyc + lat_of(i)) && (PIPE_P[i] || cyc >= m_free[i]);
        end
        m_used = '0; m_denied = 0; m_first = -1;
        for (int j = 0; j < NUM_CH; j++) begin
          m_ch = (m_rr + j) % NUM_CH;
          if (m_el[m_ch]) begin
            if (m_used[lat_of(m_ch)]) m_denied = 1;
            else begin
              m_grant[m_ch] = 1'b1;
              m_used[lat_of(m_ch)] = 1'b1;
              if (m_first < 0) m_first = m_ch;
            end
          end
        end
        for (int i = 0; i < NUM_CH; i++) begin
          if (m_grant[i]) begin
            owner[cyc + lat_of(i)] = i;
            if (!PIPE_P[i]) m_free[i] = cyc + lat_of(i);
          end
        end
        if (m_denied) m_rr = (m_first + 1) % NUM_CH;
      end
      checks++;
      if (ch_grant !== m_grant) begin
        failures++;
        $display("FAIL model_grant cyc=%0d got=%b want=%b", cyc, ch_grant, m_grant);
      end
      // No grant may target a slot the scheduler already holds
      m_slot_sh = dut.slot_q >> 1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_grant[i] === 1'b1) begin
          checks++;
          if (m_slot_sh[lat_of(i)] !== 1'b0) begin
            failures++;
            $display("FAIL slot_double_book cyc=%0d ch=%0d got=%b want=0", cyc, i, m_slot_sh[lat_of(i)]);
          end
        end
      end
      cyc++;
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_data[i*DATA_W +: DATA_W] = $urandom;
      ch_tag[i*TAG_W +: TAG_W]    = TAG_W'($urandom);
    end
    if (rand_br) begin
      ch_branch       = NUM_CH'($urandom);
      ch_branch_taken = NUM_CH'($urandom);
    end else begin
      ch_branch       = '0;
      ch_branch_taken = '0;
    end
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    ch_req = '0;
    next_cycle();
    reset  = 1'b0;
  endtask

  // ---------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1; ch_req = '1;
    ch_data = '0; ch_tag = '0; ch_branch = '0; ch_branch_taken = '0;
    @(posedge clk); #1;
    mon_en = 1;
    @(negedge clk);
    checks++;
    if (ch_grant !== '0) begin
      failures++; $display("FAIL reset_grant got=%b want=0", ch_grant);
    end
    checks++;
    if ({cdb_valid, cdb_branch, cdb_branch_taken} !== 3'b000 || cdb_data !== '0 || cdb_tag !== '0) begin
      failures++;
      $display("FAIL reset_cdb got v=%b br=%b tk=%b tag=%0d data=%h want all 0",
               cdb_valid, cdb_branch, cdb_branch_taken, cdb_tag, cdb_data);
    end
    next_cycle();
    reset = 1'b0; ch_req = '0;
    @(negedge clk);
    checks++;
    if (cdb_valid !== 1'b0 || ch_grant !== '0) begin
      failures++; $display("FAIL post_reset_idle got v=%b grant=%b want 0/0", cdb_valid, ch_grant);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int t = 0; t < 9; t++) begin
      ch_req = (t <= 2) ? 4'b0010 : 4'b0000;
      if (t >= 3 && t <= 5) ch_tag[1*TAG_W +: TAG_W] = TAG_W'(t + 2);
      @(negedge clk);
      if (t <= 2) begin
        checks++;
        if (ch_grant !== 4'b0010) begin
          failures++; $display("FAIL b2b_grant t=%0d got=%b want=0010", t, ch_grant);
        end
      end
      checks++;
      if (cdb_valid !== ((t >= 4 && t <= 6) ? 1'b1 : 1'b0)) begin
        failures++; $display("FAIL b2b_valid t=%0d got=%b", t, cdb_valid);
      end
      if (t >= 4 && t <= 6) begin
        checks++;
        if (cdb_tag !== TAG_W'(t + 1)) begin
          failures++; $display("FAIL b2b_tag t=%0d got=%0d want=%0d", t, cdb_tag, t + 1);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_lat1_contention();
    do_reset();
    for (int t = 0; t < 8; t++) begin
      ch_req = 4'b1001;
      ch_tag[0*TAG_W +: TAG_W] = TAG_W'(10 + t);
      ch_tag[3*TAG_W +: TAG_W] = TAG_W'(20 + t);
      @(negedge clk);
      checks++;
      if (ch_grant !== ((t % 2 == 0) ? 4'b0001 : 4'b1000)) begin
        failures++; $display("FAIL contention_grant t=%0d got=%b", t, ch_grant);
      end
      checks++;
      if (cdb_valid !== ((t >= 2) ? 1'b1 : 1'b0)) begin
        failures++; $display("FAIL contention_valid t=%0d got=%b", t, cdb_valid);
      end
      if (t >= 2) begin
        checks++;
        if (cdb_tag !== TAG_W'(((t - 2) % 2 == 0) ? 10 + t - 1 : 20 + t - 1)) begin
          failures++; $display("FAIL contention_tag t=%0d got=%0d", t, cdb_tag);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_reservation_wins();
    do_reset();
    for (int t = 0; t < 7; t++) begin
      ch_req = (t == 0) ? 4'b0010 : (t == 2 || t == 3) ? 4'b0001 : 4'b0000;
      if (t == 3) ch_tag[1*TAG_W +: TAG_W] = TAG_W'(33);
      if (t == 4) ch_tag[0*TAG_W +: TAG_W] = TAG_W'(44);
      @(negedge clk);
      if (t == 0 || t == 2 || t == 3) begin
        checks++;
        if (ch_grant !== ((t == 0) ? 4'b0010 : (t == 2) ? 4'b0000 : 4'b0001)) begin
          failures++; $display("FAIL reserve_grant t=%0d got=%b", t, ch_grant);
        end
      end
      if (t == 4 || t == 5) begin
        checks++;
        if (cdb_valid !== 1'b1 || cdb_tag !== TAG_W'((t == 4) ? 33 : 44)) begin
          failures++; $display("FAIL reserve_result t=%0d got v=%b tag=%0d", t, cdb_valid, cdb_tag);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_non_pipelined();
    do_reset();
    for (int t = 0; t < 20; t++) begin
      ch_req = 4'b0100;
      ch_tag[2*TAG_W +: TAG_W] = TAG_W'(40 + t);
      @(negedge clk);
      checks++;
      if (ch_grant[2] !== ((t % 6 == 0) ? 1'b1 : 1'b0)) begin
        failures++; $display("FAIL nonpipe_grant t=%0d got=%b", t, ch_grant[2]);
      end
      checks++;
      if (cdb_valid !== ((t >= 7 && (t - 1) % 6 == 0) ? 1'b1 : 1'b0)) begin
        failures++; $display("FAIL nonpipe_valid t=%0d got=%b", t, cdb_valid);
      end
      if (t >= 7 && (t - 1) % 6 == 0) begin
        checks++;
        if (cdb_tag !== TAG_W'(40 + t - 1)) begin
          failures++; $display("FAIL nonpipe_tag t=%0d got=%0d want=%0d", t, cdb_tag, 40 + t - 1);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_branch();
    do_reset();
    for (int t = 0; t < 4; t++) begin
      ch_req = (t == 0) ? 4'b1000 : 4'b0000;
      if (t == 1) begin
        ch_tag[3*TAG_W +: TAG_W] = TAG_W'(9);
        ch_branch[3]       = 1'b1;
        ch_branch_taken[3] = 1'b1;
      end
      @(negedge clk);
      if (t == 2) begin
        checks++;
`ifdef CDB_ARB_BRANCH_EN
        if ({cdb_valid, cdb_branch, cdb_branch_taken} !== 3'b011 || cdb_tag !== TAG_W'(9)) begin
          failures++;
          $display("FAIL branch_en got v=%b br=%b tk=%b tag=%0d want 0/1/1 tag 9",
                   cdb_valid, cdb_branch, cdb_branch_taken, cdb_tag);
        end
`else
        if ({cdb_valid, cdb_branch, cdb_branch_taken} !== 3'b100 || cdb_tag !== TAG_W'(9)) begin
          failures++;
          $display("FAIL branch_dis got v=%b br=%b tk=%b tag=%0d want 1/0/0 tag 9",
                   cdb_valid, cdb_branch, cdb_branch_taken, cdb_tag);
        end
`endif
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int t = 0; t < 9; t++) begin
      reset  = (t == 3);
      ch_req = (t == 0 || t == 4) ? 4'b0100 : (t == 3) ? 4'b1111 : 4'b0000;
      @(negedge clk);
      if (t == 0 || t == 3 || t == 4) begin
        checks++;
        if (ch_grant !== ((t == 3) ? 4'b0000 : 4'b0100)) begin
          failures++; $display("FAIL midreset_grant t=%0d got=%b", t, ch_grant);
        end
      end
      if (t == 4 || t == 7) begin
        checks++;
        if ({cdb_valid, cdb_branch, cdb_branch_taken} !== 3'b000 || cdb_tag !== '0 || cdb_data !== '0) begin
          failures++;
          $display("FAIL midreset_cdb t=%0d got v=%b tag=%0d data=%h want all 0", t, cdb_valid, cdb_tag, cdb_data);
        end
      end
      next_cycle();
    end
    reset = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    rand_br = 1;
    for (int t = 0; t < 3000; t++) begin
      reset  = ($urandom_range(0, 199) == 0);
      ch_req = ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom) & NUM_CH'($urandom)
                                           : NUM_CH'($urandom) | NUM_CH'($urandom);
      @(negedge clk);
      next_cycle();
    end
    reset   = 1'b0;
    rand_br = 0;
    ch_req  = '0;
    for (int t = 0; t < 20; t++) next_cycle();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_lat1_contention();
    test_reservation_wins();
    test_non_pipelined();
    test_branch();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
